// File: rtl/exec_ctrl_mdu.sv
// ---------------------------------------------------------------------------
// exec_ctrl_mdu
//
// Execute-stage controller for a MIPS-style pipeline. It holds two parts:
//  * A combinational ALU-control decoder (alu_op + funct -> ALU op code,
//    result-mux select, shifter enable, jump-register, illegal funct).
//  * A bit-serial multiply/divide unit that owns the HI/LO registers.
//    MULT, MULTU and DIVU take XLEN cycles (one bit per cycle), and the
//    pipeline is stalled only for instructions that touch HI/LO.
//
// Ports
//  clk, rst          rising-edge clock, synchronous active-high reset
//  nop               current EX instruction is a bubble
//  alu_op[1:0]       main-decoder class: 00 ld/st, 01 branch, 10 R-type, 11 andi
//  funct[5:0]        R-type function field
//  rs_val, rt_val    forwarded operands (XLEN)
//  operation[2:0]    ALU op code
//  result_sel[1:0]   EX result mux: 00 ALU, 01 HI, 10 LO, 11 shifter
//  sht_en, jr        shifter enable, jump-register
//  illegal           unknown R-type funct
//  stall             hold the pipeline (HI/LO access while the MDU is busy)
//  busy              MDU iterating
//  div_zero          one-cycle pulse after a DIVU by zero
//  hi, lo            architectural HI/LO registers (XLEN)
// ---------------------------------------------------------------------------
module exec_ctrl_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            nop,
  input  logic [1:0]      alu_op,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic [2:0]      operation,
  output logic [1:0]      result_sel,
  output logic            sht_en,
  output logic            jr,
  output logic            illegal,
  output logic            stall,
  output logic            busy,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_JR    = 6'd8;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi;    // MUL: running upper product; DIV: remainder
  logic [XLEN-1:0] acc_lo;    // MUL: multiplier bits;       DIV: dividend/quotient
  logic [XLEN-1:0] opnd;      // MUL: multiplicand;          DIV: divisor
  logic            neg;       // MULT result must be negated at the end

  logic active, rtype, hilo_use, issue, last_step;

  // Reset and bubbles both suppress every decode output and any MDU start.
  assign active   = !rst && !nop;
  assign rtype    = active && (alu_op == 2'b10);
  assign hilo_use = rtype && (funct inside {F_MFHI, F_MFLO, F_MTHI, F_MTLO,
                                            F_MULT, F_MULTU, F_DIVU});
  assign busy      = (state != S_IDLE);
  assign stall     = busy && hilo_use;
  // stall is never raised in IDLE, so every R-type seen in IDLE issues.
  assign issue     = rtype && (state == S_IDLE);
  assign last_step = busy && (cnt == CW'(1));

  // -------------------------------------------------------------------------
  // ALU control decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case tree so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    operation  = 3'b000;
    result_sel = 2'b00;
    sht_en     = 1'b0;
    jr         = 1'b0;
    illegal    = 1'b0;
    if (active) begin
      case (alu_op)
        2'b00: operation = 3'b010;
        2'b01: operation = 3'b110;
        2'b11: operation = 3'b000;
        default: begin
          case (funct)
            F_AND: operation = 3'b000;
            F_OR:  operation = 3'b001;
            F_ADD: operation = 3'b010;
            F_SUB: operation = 3'b110;
            F_SLT: operation = 3'b111;
            F_SLL: begin
              sht_en     = 1'b1;
              result_sel = 2'b11;
            end
            F_JR: begin
              operation = 3'b010;
              jr        = 1'b1;
            end
            F_MFHI: result_sel = 2'b01;
            F_MFLO: result_sel = 2'b10;
            F_MULT, F_MULTU, F_DIVU, F_MTHI, F_MTLO: operation = 3'b000;
            default: illegal = 1'b1;
          endcase
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Operand preparation: MULT works on magnitudes. Negating the most
  // negative value yields the same bit pattern, which read as unsigned is
  // exactly its magnitude.
  // -------------------------------------------------------------------------
  logic            is_mult;
  logic [XLEN-1:0] rs_mag, rt_mag;

  assign is_mult = (funct == F_MULT);
  assign rs_mag  = (is_mult && rs_val[XLEN-1]) ? -rs_val : rs_val;
  assign rt_mag  = (is_mult && rt_val[XLEN-1]) ? -rt_val : rt_val;

  // -------------------------------------------------------------------------
  // One iteration of shift-add multiply or restoring divide
  // -------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff, step_hi, step_lo;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_prod, mul_res;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // Only consumed when div_shift >= opnd, so the result fits in XLEN bits.
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (state == S_DIV) begin
      step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    mul_prod = {step_hi, step_lo};
    mul_res  = neg ? -mul_prod : mul_prod;
  end

  // -------------------------------------------------------------------------
  // MDU FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue && (funct == F_MULT || funct == F_MULTU))
          state_nxt = S_MUL;
        else if (issue && funct == F_DIVU && rt_val != '0)
          state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (last_step) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and HI/LO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      neg      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= 1'b0;
      if (state == S_IDLE) begin
        if (issue) begin
          case (funct)
            F_MULT, F_MULTU: begin
              acc_hi <= '0;
              acc_lo <= rt_mag;
              opnd   <= rs_mag;
              neg    <= is_mult && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
              cnt    <= CW'(XLEN);
            end
            F_DIVU: begin
              if (rt_val == '0) begin
                // Divide by zero completes immediately with a fixed result.
                lo       <= '1;
                hi       <= rs_val;
                div_zero <= 1'b1;
              end else begin
                acc_hi <= '0;
                acc_lo <= rs_val;
                opnd   <= rt_val;
                neg    <= 1'b0;
                cnt    <= CW'(XLEN);
              end
            end
            F_MTHI: hi <= rs_val;
            F_MTLO: lo <= rs_val;
            default: ;
          endcase
        end
      end else begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt - CW'(1);
        // Final bit: publish straight from the step logic so the result is
        // visible on the same edge the counter reaches zero.
        if (last_step) begin
          if (state == S_MUL) begin
            hi <= mul_res[2*XLEN-1:XLEN];
            lo <= mul_res[XLEN-1:0];
          end else begin
            hi <= step_hi;
            lo <= step_lo;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_ctrl_mdu.sv
// ---------------------------------------------------------------------------
// tb_exec_ctrl_mdu
//
// Self-checking bench for exec_ctrl_mdu (XLEN = 32). Decode is exercised
// from a table of {inputs, expected outputs} records; the multiply/divide
// unit is checked against a reference computed with native 64-bit
// arithmetic, using directed corner cases followed by random operations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_exec_ctrl_mdu;

  localparam int XLEN = 32;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_JR    = 6'd8;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rs;
    logic       sht;
    logic       jr;
    logic       ill;
  } dec_t;

  typedef struct {
    logic       n;
    logic [1:0] a;
    logic [5:0] f;
    dec_t       e;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            nop;
  logic [1:0]      alu_op;
  logic [5:0]      funct;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [2:0]      operation;
  logic [1:0]      result_sel;
  logic            sht_en;
  logic            jr;
  logic            illegal;
  logic            stall;
  logic            busy;
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  // Reference copy of the architectural HI/LO registers.
  logic [XLEN-1:0] m_hi = '0;
  logic [XLEN-1:0] m_lo = '0;

  exec_ctrl_mdu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .nop        (nop),
    .alu_op     (alu_op),
    .funct      (funct),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .operation  (operation),
    .result_sel (result_sel),
    .sht_en     (sht_en),
    .jr         (jr),
    .illegal    (illegal),
    .stall      (stall),
    .busy       (busy),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    nop    = 1'b1;
    alu_op = 2'b00;
    funct  = 6'd0;
  endtask

  task automatic present(input logic [5:0] f, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
    nop    = 1'b0;
    alu_op = 2'b10;
    funct  = f;
    rs_val = a;
    rt_val = b;
  endtask

  // Present an R-type for one edge, then replace it with a bubble and
  // scramble the operand buses so later changes cannot leak into the MDU.
  task automatic issue(input logic [5:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b);
    present(f, a, b);
    tick();
    bubble();
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Decode table straight from the instruction-class definitions.
  function automatic dec_t dec_ref(input logic n, input logic [1:0] a,
                                   input logic [5:0] f);
    dec_t d;
    d.op = 3'b000; d.rs = 2'b00; d.sht = 1'b0; d.jr = 1'b0; d.ill = 1'b0;
    if (n) return d;
    case (a)
      2'b00: d.op = 3'b010;
      2'b01: d.op = 3'b110;
      2'b11: d.op = 3'b000;
      default: begin
        case (f)
          F_AND: d.op = 3'b000;
          F_OR:  d.op = 3'b001;
          F_ADD: d.op = 3'b010;
          F_SUB: d.op = 3'b110;
          F_SLT: d.op = 3'b111;
          F_SLL: begin d.sht = 1'b1; d.rs = 2'b11; end
          F_JR:  begin d.op = 3'b010; d.jr = 1'b1; end
          F_MFHI: d.rs = 2'b01;
          F_MFLO: d.rs = 2'b10;
          F_MULT, F_MULTU, F_DIVU, F_MTHI, F_MTLO: ;
          default: d.ill = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

  function automatic vec_t mk(input logic n, input logic [1:0] a,
                              input logic [5:0] f, input logic [2:0] op,
                              input logic [1:0] rs, input logic sht,
                              input logic j, input logic ill);
    vec_t v;
    v.n = n; v.a = a; v.f = f;
    v.e.op = op; v.e.rs = rs; v.e.sht = sht; v.e.jr = j; v.e.ill = ill;
    return v;
  endfunction

  // HI/LO effect of one MDU instruction, by plain arithmetic. Returns the
  // number of busy cycles expected (0 for single-edge instructions).
  function automatic int ref_op(input logic [5:0] f, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b,
                                inout logic [XLEN-1:0] h,
                                inout logic [XLEN-1:0] l);
    longint unsigned up;
    longint          sp;
    case (f)
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32]; l = up[31:0];
        return XLEN;
      end
      F_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        h = sp[63:32]; l = sp[31:0];
        return XLEN;
      end
      F_DIVU: begin
        if (b == 0) begin
          l = '1; h = a;
          return 0;
        end
        l = a / b; h = a % b;
        return XLEN;
      end
      F_MTHI: begin h = a; return 0; end
      F_MTLO: begin l = a; return 0; end
      default: return 0;
    endcase
  endfunction

  // Drive an instruction that never touches HI/LO, with fresh operands.
  task automatic drive_other();
    int s;
    s = $urandom_range(0, 9);
    nop    = (s == 9);
    rs_val = $urandom;
    rt_val = $urandom;
    case (s)
      0: alu_op = 2'b00;
      1: alu_op = 2'b01;
      2: alu_op = 2'b11;
      default: begin
        alu_op = 2'b10;
        case ($urandom_range(0, 6))
          0: funct = F_ADD;
          1: funct = F_SUB;
          2: funct = F_AND;
          3: funct = F_OR;
          4: funct = F_SLT;
          5: funct = F_SLL;
          default: funct = F_JR;
        endcase
      end
    endcase
  endtask

  // Issue one MDU instruction, optionally interleave unrelated traffic while
  // busy, and compare the result with the reference. Entered and left 1 time
  // unit after a rising edge.
  task automatic run_mdu(input logic [5:0] f, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input bit noise);
    logic [XLEN-1:0] eh, el;
    int lat, cycles;
    eh = m_hi;
    el = m_lo;
    lat = ref_op(f, a, b, eh, el);
    issue(f, a, b);
    if (lat > 0) begin
      cycles = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (!busy) break;
        cycles++;
        check("hi_hold_busy", hi, m_hi);
        check("lo_hold_busy", lo, m_lo);
        if (noise) begin
          drive_other();
          #1;
          check("no_stall_other", stall, 1'b0);
        end
      end
      check("mdu_latency", cycles, lat);
    end else begin
      @(negedge clk);
    end
    check("mdu_busy_done", busy, 1'b0);
    check("mdu_hi", hi, eh);
    check("mdu_lo", lo, el);
    check("div_zero_pulse", div_zero, (f == F_DIVU && b == 0));
    m_hi = eh;
    m_lo = el;
    bubble();
    tick();
    @(negedge clk);
    check("div_zero_clear", div_zero, 1'b0);
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  vec_t vecs[$];

  initial begin
    logic [XLEN-1:0] eh, el, a, b;
    int lat;

    // Decode vectors: explicit anchors first, then the full R-type sweep.
    vecs.push_back(mk(0, 2'b00, 6'd13,  3'b010, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 6'd42,  3'b110, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 6'd1,   3'b000, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, F_ADD,  3'b010, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, F_SLT,  3'b111, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, F_SLL,  3'b000, 2'b11, 1, 0, 0));
    vecs.push_back(mk(0, 2'b10, F_JR,   3'b010, 2'b00, 0, 1, 0));
    vecs.push_back(mk(0, 2'b10, F_MFLO, 3'b000, 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 6'd1,   3'b000, 2'b00, 0, 0, 1));
    vecs.push_back(mk(1, 2'b10, F_SLL,  3'b000, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 6'd0,   3'b000, 2'b00, 0, 0, 0));
    for (int n = 0; n < 2; n++)
      for (int f = 0; f < 64; f++)
        vecs.push_back('{n: n[0], a: 2'b10, f: f[5:0],
                         e: dec_ref(n[0], 2'b10, f[5:0])});

    // ---- reset: decode forced to zero, no MDU start, registers cleared ----
    rst = 1'b1;
    present(F_SLL, 32'h5, 32'h7);
    tick();
    @(negedge clk);
    check("rst_operation", operation, 3'b000);
    check("rst_result_sel", result_sel, 2'b00);
    check("rst_sht_en", sht_en, 1'b0);
    tick();
    present(6'd5, 32'h5, 32'h7);
    #1;
    check("rst_illegal", illegal, 1'b0);
    present(F_MULTU, 32'h5, 32'h7);
    #1;
    check("rst_stall", stall, 1'b0);
    tick();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_div_zero", div_zero, 1'b0);
    tick();
    // First instruction after reset is accepted immediately.
    rst = 1'b0;
    present(F_MTLO, 32'h77, 32'h0);
    tick();
    bubble();
    @(negedge clk);
    check("post_rst_mtlo", lo, 32'h77);
    check("post_rst_busy", busy, 1'b0);
    m_lo = 32'h77;
    tick();

    // ---- decode table ----
    foreach (vecs[i]) begin
      nop    = vecs[i].n;
      alu_op = vecs[i].a;
      funct  = vecs[i].f;
      @(negedge clk);
      check($sformatf("dec_op[%0d]", i), operation, vecs[i].e.op);
      check($sformatf("dec_rs[%0d]", i), result_sel, vecs[i].e.rs);
      check($sformatf("dec_sht[%0d]", i), sht_en, vecs[i].e.sht);
      check($sformatf("dec_jr[%0d]", i), jr, vecs[i].e.jr);
      check($sformatf("dec_ill[%0d]", i), illegal, vecs[i].e.ill);
      check($sformatf("dec_stall[%0d]", i), stall, 1'b0);
      // Withdraw before the edge so MDU codes in the sweep never issue.
      bubble();
      tick();
    end
    @(negedge clk);
    check("sweep_no_busy", busy, 1'b0);
    check("sweep_hi_kept", hi, m_hi);
    check("sweep_lo_kept", lo, m_lo);
    tick();

    // ---- directed arithmetic corners ----
    run_mdu(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    run_mdu(F_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);
    run_mdu(F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mult_minneg_hi", hi, 32'h4000_0000);
    check("mult_minneg_lo", lo, 32'h0000_0000);
    run_mdu(F_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_q", lo, 32'd14);
    check("divu_r", hi, 32'd2);
    run_mdu(F_DIVU, 32'h1234, 32'd0, 1'b0);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'h1234);
    run_mdu(F_MTHI, 32'hCAFE_0001, 32'd0, 1'b0);
    run_mdu(F_MTLO, 32'hBEEF_0002, 32'd0, 1'b0);

    // ---- MFLO held behind a MULTU, with an ADD slipping through ----
    a = 32'h0001_2345;
    b = 32'h0000_6789;
    eh = m_hi;
    el = m_lo;
    lat = ref_op(F_MULTU, a, b, eh, el);
    issue(F_MULTU, a, b);
    tick();
    for (int k = 2; k <= 32; k++) begin
      if (k == 10) present(F_ADD, 32'h1, 32'h2);
      else         present(F_MFLO, 32'h0, 32'h0);
      @(negedge clk);
      if (k == 10) begin
        check("add_in_busy_op", operation, 3'b010);
        check("add_in_busy_stall", stall, 1'b0);
      end else begin
        check("mflo_stall", stall, 1'b1);
        check("mflo_result_sel", result_sel, 2'b10);
      end
      tick();
    end
    present(F_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check("mflo_release_busy", busy, 1'b0);
    check("mflo_release_stall", stall, 1'b0);
    check("mflo_release_sel", result_sel, 2'b10);
    check("mflo_value", lo, el);
    m_hi = eh;
    m_lo = el;
    tick();
    bubble();
    @(negedge clk);
    check("mflo_no_action", busy, 1'b0);
    check("mflo_hi_kept", hi, m_hi);
    tick();

    // ---- MTHI stalled behind a MULT, issues on the first idle cycle ----
    a = 32'hFFFF_FF00;
    b = 32'h0000_0300;
    eh = m_hi;
    el = m_lo;
    lat = ref_op(F_MULT, a, b, eh, el);
    issue(F_MULT, a, b);
    present(F_MTHI, 32'h0000_DEAD, 32'h0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("mthi_stall", stall, 1'b1);
      check("mthi_hi_hold", hi, m_hi);
      tick();
    end
    @(negedge clk);
    check("mthi_release_stall", stall, 1'b0);
    check("mult_hi_before_mthi", hi, eh);
    tick();
    bubble();
    @(negedge clk);
    check("mthi_after_stall_hi", hi, 32'h0000_DEAD);
    check("mthi_after_stall_lo", lo, el);
    check("mthi_after_busy", busy, 1'b0);
    m_hi = 32'h0000_DEAD;
    m_lo = el;
    tick();

    // ---- reset in the middle of a MULTU discards it ----
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    present(F_MTHI, 32'h0000_00A5, 32'h0);
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    tick();
    bubble();
    @(negedge clk);
    check("midrst_mthi", hi, 32'h0000_00A5);
    m_hi = 32'h0000_00A5;
    m_lo = 32'h0;
    repeat (40) tick();
    @(negedge clk);
    check("midrst_no_late_write_hi", hi, m_hi);
    check("midrst_no_late_write_lo", lo, m_lo);
    check("midrst_idle", busy, 1'b0);
    tick();

    // ---- random MDU traffic with unrelated instructions interleaved ----
    for (int t = 0; t < 40; t++) begin
      logic [5:0] f;
      logic [XLEN-1:0] opa, opb;
      logic [XLEN-1:0] pick [2];
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 7))
          0: pick[j] = 32'h0;
          1: pick[j] = 32'hFFFF_FFFF;
          2: pick[j] = 32'h8000_0000;
          3: pick[j] = $urandom_range(0, 20);
          default: pick[j] = $urandom;
        endcase
      end
      opa = pick[0];
      opb = pick[1];
      case ($urandom_range(0, 5))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIVU;
        3: begin f = F_DIVU; opb = 32'h0; end
        4: f = F_MTHI;
        default: f = F_MTLO;
      endcase
      run_mdu(f, opa, opb, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
